// File: rtl/srsystem_pkg.sv
// Shared constants and helpers for the serial reception datapath.
package srsystem_pkg;

    localparam int SRS_DATA_W = 8;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Frame positions (1-based rxck pulse number) for the default word width
    localparam int POS_PARITY = SRS_DATA_W + 1;
    localparam int POS_STOP   = SRS_DATA_W + 2;

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 3);
    endfunction

    function automatic int pos_parity(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int pos_stop(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/srsystem_rx_sync.sv
// Two-flop line synchroniser plus saturating low-run start filter.
module srsystem_rx_sync #(
    parameter int START_FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    input  logic en,
    output logic rxo,
    output logic st
);
    localparam int FW = $clog2(START_FILT + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(START_FILT);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [FW-1:0] run_q, run_d;

    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        run_d   = run_q;
        // Any high sample or disable restarts the low-run measurement
        if (sync2_q || !en)
            run_d = '0;
        else if (run_q != FILT_MAX)
            run_d = run_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            run_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            run_q   <= run_d;
        end
    end

    assign rxo = sync2_q;
    assign st  = (run_q == FILT_MAX);

endmodule

// File: rtl/srsystem_rx_datapath.sv
// Receive datapath: conditions rxd, shifts/checks frames on FSM strobes, holds the output word.
// Optional feature: define SRS_RX_OVERRUN_EN to add the ovr output and protect an unacknowledged word.
module srsystem_rx_datapath
    import srsystem_pkg::*;
#(
    parameter int DATA_W     = SRS_DATA_W,
    parameter int PARITY_ODD = PAR_EVEN,
    parameter int START_FILT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              en,
    input  logic              cdc,
    input  logic              rxck,
    input  logic              pd,
    input  logic              dry,
    input  logic              ack,
    output logic              st,
    output logic              rxo,
    output logic              rxf,
    output logic              p,
    output logic              sp,
`ifdef SRS_RX_OVERRUN_EN
    output logic              ovr,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);
    localparam int CW = bit_cnt_w(DATA_W);
    localparam logic [CW-1:0] CNT_DATA = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_PAR  = CW'(pos_parity(DATA_W) - 1);
    localparam logic [CW-1:0] CNT_STOP = CW'(pos_stop(DATA_W));
    localparam logic          PAR_BIT  = 1'(PARITY_ODD);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              acc_q, acc_d;
    logic              rxf_q, rxf_d;
    logic              p_q, p_d;
    logic              sp_q, sp_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              ovr_q, ovr_d;
    logic              hold;

    srsystem_rx_sync #(
        .START_FILT (START_FILT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .en  (en),
        .rxo (rxo),
        .st  (st)
    );

`ifdef SRS_RX_OVERRUN_EN
    assign hold = dv_q && !ack;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        acc_d  = acc_q;
        p_d    = p_q;
        sp_d   = sp_q;
        dout_d = dout_q;
        dv_d   = dv_q;
        ovr_d  = ovr_q;

        if (rxck && cnt_q < CNT_STOP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_DATA) begin
                // Shift right so the first bit received lands in bit 0
                sh_d  = {rxo, sh_q[DATA_W-1:1]};
                acc_d = acc_q ^ rxo;
            end else if (cnt_q == CNT_PAR) begin
                p_d = ((acc_q ^ rxo) == PAR_BIT);
            end else begin
                sp_d = rxo;
            end
        end

        if (!cdc) begin
            cnt_d = '0;
            sh_d  = '0;
            acc_d = 1'b0;
            p_d   = 1'b0;
            sp_d  = 1'b0;
        end
        rxf_d = (cnt_d >= CNT_DATA);

        // Transfer reads sh_q, so a simultaneous clear still delivers the old word
        if (pd) begin
            if (hold)
                ovr_d = 1'b1;
            else
                dout_d = sh_q;
        end else if (ack) begin
            ovr_d = 1'b0;
        end

        if (dry)
            dv_d = 1'b1;
        else if (ack && dv_q)
            dv_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            sh_q   <= '0;
            acc_q  <= 1'b0;
            rxf_q  <= 1'b0;
            p_q    <= 1'b0;
            sp_q   <= 1'b0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            rxf_q  <= rxf_d;
            p_q    <= p_d;
            sp_q   <= sp_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            ovr_q  <= ovr_d;
        end
    end

    assign rxf        = rxf_q;
    assign p          = p_q;
    assign sp         = sp_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
`ifdef SRS_RX_OVERRUN_EN
    assign ovr        = ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = ovr_q;
`endif

endmodule

// File: doc/srsystem_rx_datapath.md
Name: srsystem_rx_datapath

Overview:
- Receive datapath for the serial reception system, directly upstream of the reception control FSM.
- Conditions the raw serial line and supplies the FSM's status inputs `st`, `p`, `sp`, `rxo`, `rxf`.
- Executes the FSM's control strobes: `cdc` (clear), `rxck` (sample/shift), `pd` (parallel transfer).
- Presents the received word to the downstream consumer; `dry`/`ack` form the consumer handshake.

Parameters:
- DATA_W, 8, data bits per frame (5..16).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- START_FILT, 3, consecutive low samples on the synchronised line required to flag a start bit (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- rxd  in  1  raw serial line, asynchronous, idle high
- en  in  1  receiver enable; start detection is gated by it
- cdc  in  1  FSM clear control, active-low; 0 = clear frame datapath
- rxck  in  1  FSM sample/shift strobe, one clk per bit
- pd  in  1  FSM parallel-transfer strobe
- dry  in  1  FSM data-ready indication (qualifies dout_valid)
- ack  in  1  consumer acknowledge (shared with FSM)
- st  out  1  start bit detected
- rxo  out  1  current synchronised line sample
- rxf  out  1  data field full
- p  out  1  parity check passed
- sp  out  1  stop bit sampled high
- dout  out  DATA_W  received word
- dout_valid  out  1  dout holds an unacknowledged word

Behaviour:
- Reset (`rst`=0 at a clk edge): all registers cleared except the synchroniser, which resets to 1 (idle line).
  - rxo=1; st, rxf, p, sp, dout_valid = 0; dout = 0.
- Synchroniser: 2-flop on rxd; `rxo` = second flop. Latency rxd→rxo = 2 clk.
- Start filter: low-run counter, saturating at START_FILT.
  - Increments while rxo=0 and en=1; cleared when rxo=1 or en=0.
  - st = 1 while the counter equals START_FILT.
  - A glitch shorter than START_FILT clk never raises st.
- Frame clear: when cdc=0, the following are cleared in the same edge: bit counter, shift register, parity accumulator, rxf, p, sp. dout/dout_valid are unaffected.
- Bit counter: width $clog2(DATA_W+3), counts rxck pulses since clear; pulse number k = counter value + 1.
  - k = 1..DATA_W: rxo shifted into the shift register LSB-first (first data bit ends in bit 0); parity accumulator ^= rxo.
  - k = DATA_W+1 (parity bit): p <= (acc ^ rxo) == PARITY_ODD.
  - k = DATA_W+2 (stop bit): sp <= rxo.
  - Further pulses: ignored. Counter saturates at DATA_W+2; no wrap.
- rxf = 1 once the counter ≥ DATA_W. Registered, so visible the clk after the DATA_W-th pulse.
- Transfer: pd=1 → dout <= shift register, next edge.
- Handshake:
  - dout_valid is set on the edge where dry=1, cleared on the edge where ack=1 with dout_valid=1.
  - dry and ack in the same cycle: the set wins.
  - dout is stable while dout_valid=1 unless a new pd arrives (see overrun).
- Simultaneous events:
  - cdc=0 together with rxck: the clear wins, no shift.
  - cdc=0 together with pd: the transfer uses pre-clear shift contents.
- Reset mid-frame: immediate return to the reset values above; the next frame starts only on a fresh start filter.

Optional Feature:
- SRS_RX_OVERRUN_EN defined:
  - Adds output `ovr` (1 bit, reset 0).
  - ovr sets when pd=1 while dout_valid=1 and ack=0; dout is then NOT overwritten.
  - ovr clears on the next ack.
- Undefined: no ovr port; pd always overwrites dout.

Decomposition:
- Package srsystem_pkg:
  - DATA_W default.
  - Parity mode constants PAR_EVEN=0, PAR_ODD=1.
  - Bit-counter width function.
  - Frame position constants: POS_PARITY = DATA_W+1, POS_STOP = DATA_W+2.
- One sub-module, srsystem_rx_sync: 2-flop synchroniser plus start filter, producing rxo and st.

Test Plan:
- Reset: rst=0 for 2 clk with rxd=0 → rxo=1, st=0, dout=0, dout_valid=0. Release → rxo=0 after 2 clk, st=1 after 2+3 clk.
- Glitch: rxd low for 2 clk, en=1, START_FILT=3 → st never asserted.
- Good frame: 0xA5 LSB-first, even parity bit 0, stop 1, rxck once per bit, then pd, dry →
  - rxf=1 after the 8th pulse.
  - p=1, sp=1.
  - dout=0xA5, dout_valid=1 until ack.
- Parity/stop error: 0x01 with parity bit 0 (even) and stop 0 → p=0, sp=0; dout still 0x01 after pd.
- Clear mid-frame: cdc=0 after 4 rxck pulses → counter 0, rxf=0. Next full frame 0x3C → dout=0x3C.
- Overrun (SRS_RX_OVERRUN_EN): second pd while dout_valid=1 with 0x5A pending → ovr=1, dout stays 0x5A; ack → ovr=0, dout_valid=0.
